uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 15 +
 rtl/uart_tx_serializer.sv | 67 ++++++
 rtl/uart_tx_sched.sv | 126 ++++++++++++
 tb/tb_uart_tx_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared state encoding and frame constants for the UART transmit scheduler
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int FRAME_BITS_BASE   = 10;
    localparam int FRAME_BITS_PARITY = 11;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - one-byte UART frame shifter with latched divisor; UART_TX_SCHED_PARITY_EN adds even parity
module uart_tx_serializer
    import uart_tx_sched_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       data,
    input  logic [DIV_W-1:0] div,
    output logic             tx,
    output logic             busy,
    output logic             done
);

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
    logic [FRAME_BITS-1:0] frame;
    assign frame = {1'b1, ^data, data, 1'b0};
`else
    localparam int FRAME_BITS = FRAME_BITS_BASE;
    logic [FRAME_BITS-1:0] frame;
    assign frame = {1'b1, data, 1'b0};
`endif

    logic [FRAME_BITS-1:0] shreg;
    logic [DIV_W-1:0]      div_lat;
    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            bit_cnt;
    logic                  busy_r;
    logic                  bit_end;

    assign bit_end = (div_cnt == div_lat);
    // Last cycle of the stop bit; the scheduler leaves SHIFT on this strobe.
    assign done    = busy_r && bit_end && (bit_cnt == 4'(FRAME_BITS - 1));
    assign tx      = busy_r ? shreg[0] : 1'b1;
    assign busy    = busy_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            shreg   <= '1;
            div_lat <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            busy_r  <= 1'b1;
            shreg   <= frame;
            div_lat <= div;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (busy_r) begin
            if (bit_end) begin
                div_cnt <= '0;
                shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
                if (done) begin
                    busy_r <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin UART transmit scheduler with line lock and lock timeout; UART_TX_SCHED_PARITY_EN selects parity frames
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int NUM_REQ  = 3,
    parameter  int DIV_W    = 16,
    parameter  int LOCK_TMO = 64,
    localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [DIV_W-1:0]     baud_div,
    output logic                 tx,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    localparam int TW = $clog2(LOCK_TMO + 1);

    state_t             state;
    state_t             state_nxt;
    logic [GW-1:0]      rr_ptr;
    logic [GW-1:0]      cand;
    logic [GW-1:0]      pick;
    logic               locked;
    logic [GW-1:0]      lock_id;
    logic [DIV_W-1:0]   tmo_div;
    logic [TW-1:0]      tmo_cnt;
    logic [NUM_REQ-1:0] elig;
    logic [7:0]         grant_data;
    logic               accept;
    logic               ser_done;

    assign elig       = locked ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
    assign grant_data = req_data[8*int'(cand) +: 8];
    assign accept     = (state == ST_LOAD) && req_valid[cand];
    assign req_ready  = accept ? (NUM_REQ'(1) << cand) : '0;

    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|elig) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = accept ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: if (ser_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant pointer and lock only move on a real accept, so a withdrawn request leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            cand     <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
            lock_id  <= '0;
            tmo_div  <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (state == ST_IDLE && |elig) begin
                cand <= pick;
            end
            if (accept) begin
                grant_id <= cand;
                rr_ptr   <= (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
                locked   <= (grant_data != ASCII_LF);
                lock_id  <= cand;
            end
            if (state == ST_IDLE && locked && !req_valid[lock_id]) begin
                if (tmo_div == baud_div) begin
                    tmo_div <= '0;
                    if (tmo_cnt == TW'(LOCK_TMO - 1)) begin
                        tmo_cnt <= '0;
                        locked  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end else begin
                    tmo_div <= tmo_div + 1'b1;
                end
            end else begin
                tmo_div <= '0;
                tmo_cnt <= '0;
            end
        end
    end

    uart_tx_serializer #(
        .DIV_W (DIV_W)
    ) u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .data  (grant_data),
        .div   (baud_div),
        .tx    (tx),
        .busy  (busy),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [15:0] baud_div;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] qmem [3][8];
    int  qh [3];
    int  qt [3];
    bit  popf [3];
    int  ready_cnt [3];
    int  ready_cyc [3];
    bit  auto_feed;
    int  start_cyc;
    int  g;

    uart_tx_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .baud_div  (baud_div),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_SCHED_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push(input int i, input logic [7:0] d);
        qmem[i][qt[i]] = d;
        qt[i]++;
    endtask

    task automatic clear_feed();
        for (int i = 0; i < 3; i++) begin
            qh[i] = 0; qt[i] = 0; popf[i] = 0; ready_cnt[i] = 0;
        end
    endtask

    // Advance to the next falling edge and play the requester side of the handshake.
    task automatic step();
        logic [2:0]  r;
        logic [2:0]  v;
        logic [23:0] d;
        @(negedge clk);
        if (auto_feed) begin
            r = req_ready;
            v = '0;
            d = '0;
            for (int i = 0; i < 3; i++) begin
                if (popf[i]) begin
                    qh[i]++;
                    popf[i] = 0;
                end
                if (qh[i] < qt[i]) begin
                    v[i] = 1'b1;
                    d[8*i +: 8] = qmem[i][qh[i]];
                end
                if (r[i]) begin
                    popf[i] = 1;
                    ready_cnt[i]++;
                    ready_cyc[i] = cyc;
                end
            end
            req_valid = v;
            req_data  = d;
        end
    endtask

    task automatic rx_frame(input int div, input logic [7:0] exp, input string tag, output int gap);
        logic [FB-1:0] got;
        int herr;
        gap = 0;
        got = '0;
        herr = 0;
        while (tx !== 1'b0 && gap < 3000) begin
            gap++;
            step();
        end
        chk({tag, "_start_timeout"}, 32'(gap < 3000), 32'd1);
        start_cyc = cyc;
        for (int b = 0; b < FB; b++) begin
            for (int c = 0; c <= div; c++) begin
                if (c == 0) got[b] = tx;
                else if (tx !== got[b]) herr++;
                if (busy !== 1'b1) herr++;
                step();
            end
        end
        chk({tag, "_frame"}, 32'(got), 32'(mk_frame(exp)));
        chk({tag, "_hold"}, herr, 0);
        chk({tag, "_idle_after"}, {30'd0, busy, tx}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_feed();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        baud_div  = 16'd3;
        auto_feed = 1'b1;
        clear_feed();
        step(); step(); step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        reset = 1'b0;
        step();

        // Single byte, 4 cycles per bit, start bit right after the ready strobe
        push(0, 8'h55);
        rx_frame(3, 8'h55, "t1", g);
        chk("t1_ready_pulses", ready_cnt[0], 1);
        chk("t1_latency", start_cyc, ready_cyc[0] + 1);
        chk("t1_grant", 32'(grant_id), 32'd0);

        // Round-robin with lock timeout between requesters
        do_reset();
        baud_div = 16'd0;
        push(0, 8'h41); push(1, 8'h42); push(2, 8'h43);
        rx_frame(0, 8'h41, "t2a", g);
        rx_frame(0, 8'h42, "t2b", g);
        chk("t2b_gap", g, 66);
        rx_frame(0, 8'h43, "t2c", g);
        chk("t2c_gap", g, 66);
        chk("t2_grant", 32'(grant_id), 32'd2);
        push(0, 8'h41); push(1, 8'h42);
        rx_frame(0, 8'h41, "t2d", g);
        chk("t2d_gap", g, 66);
        rx_frame(0, 8'h42, "t2e", g);
        chk("t2e_gap", g, 66);

        // Locked line until LF, then the waiting requester
        do_reset();
        baud_div = 16'd1;
        push(1, 8'h41); push(1, 8'h42); push(1, 8'h0A); push(2, 8'h5A);
        rx_frame(1, 8'h41, "t3a", g);
        rx_frame(1, 8'h42, "t3b", g);
        chk("t3b_gap", g, 2);
        rx_frame(1, 8'h0A, "t3c", g);
        chk("t3c_gap", g, 2);
        rx_frame(1, 8'h5A, "t3d", g);
        chk("t3d_gap", g, 2);
        chk("t3_grant", 32'(grant_id), 32'd2);

        // Reset during data bit 4
        do_reset();
        baud_div = 16'd3;
        push(0, 8'hA5);
        g = 0;
        while (tx !== 1'b0 && g < 3000) begin
            g++;
            step();
        end
        chk("t4_start_timeout", 32'(g < 3000), 32'd1);
        repeat (21) step();
        reset = 1'b1;
        step();
        chk("t4_tx_after_rst", 32'(tx), 32'd1);
        chk("t4_busy_after_rst", 32'(busy), 32'd0);
        chk("t4_grant_after_rst", 32'(grant_id), 32'd0);
        step();
        reset = 1'b0;
        clear_feed();
        push(1, 8'h31); push(0, 8'h30);
        rx_frame(3, 8'h30, "t4a", g);
        chk("t4a_grant", 32'(grant_id), 32'd0);

        // Divisor change mid-frame only affects the next frame
        do_reset();
        baud_div = 16'd3;
        push(0, 8'h0F); push(0, 8'h0A);
        fork
            rx_frame(3, 8'h0F, "t5a", g);
            begin
                repeat (12) @(negedge clk);
                baud_div = 16'd7;
            end
        join
        rx_frame(7, 8'h0A, "t5b", g);
        chk("t5b_gap", g, 2);

        // Withdrawn request leaves the pointer alone; byte 0x07 frame
        do_reset();
        baud_div = 16'd0;
        push(0, 8'h0A);
        rx_frame(0, 8'h0A, "t6a", g);
        auto_feed = 1'b0;
        step();
        req_valid = 3'b100;
        req_data  = 24'h330000;
        step();
        req_valid = 3'b000;
        step();
        chk("t6_no_frame_busy", 32'(busy), 32'd0);
        chk("t6_no_frame_tx", 32'(tx), 32'd1);
        chk("t6_grant_kept", 32'(grant_id), 32'd0);
        auto_feed = 1'b1;
        push(0, 8'h61); push(1, 8'h07); push(2, 8'h62);
        rx_frame(0, 8'h07, "t6b", g);
        chk("t6b_grant", 32'(grant_id), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
